// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, word-addressed imem and the IF/ID register, with a LOAD/RUN/HALT sequencer.
// Fetch-to-decode latency is one cycle; stallF freezes PC and IF/ID, and PCSrcD flushes IF/ID for one bubble.
module instruction_fetch #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_wdata,
  input  logic          start,
  input  logic          stallF,
  input  logic          PCSrcD,
  input  logic [31:0]   PCBranchD,
  output logic [31:0]   instrD,
  output logic [31:0]   PCPlus4D,
  output logic          validD,
  output logic [31:0]   pcF,
  output logic          halted,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
);

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  state_t      state;
  ifid_t       ifid;
  logic [31:0] pc;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] pc_next_seq;
  logic [31:0] br_target;

  // Upper PC bits are dropped here, so fetch addresses alias modulo the memory size.
  assign fetch_word  = imem[pc[AW+1:2]];
  assign pc_next_seq = pc + 32'd4;
  assign br_target   = PCBranchD & 32'hFFFF_FFFC;

  // Program memory has no reset so a loaded program survives a reset and can be re-run.
  always_ff @(posedge clk) begin
    if (imem_we && state == LOAD) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      pc          <= {RESET_PC[31:2], 2'b00};
      ifid        <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          // A stall makes the decode-side redirect stale, so it outranks PCSrcD.
          if (stallF) begin
            stall_count <= stall_count + 32'd1;
          end else if (PCSrcD) begin
            pc   <= br_target;
            ifid <= '0;
          end else if (fetch_word == HALT_WORD) begin
            state  <= HALT;
            halted <= 1'b1;
            ifid   <= '0;
          end else begin
            ifid        <= '{instr: fetch_word, pc_plus4: pc_next_seq, valid: 1'b1};
            pc          <= pc_next_seq;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  assign instrD   = ifid.instr;
  assign PCPlus4D = ifid.pc_plus4;
  assign validD   = ifid.valid;
  assign pcF      = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load, run, stall, redirect, halt, wrap and reset retention.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        start;
  logic        stallF;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] instrD;
  logic [31:0] PCPlus4D;
  logic        validD;
  logic [31:0] pcF;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0  = 32'h2008_0001;
  localparam logic [31:0] W1  = 32'h2009_0002;
  localparam logic [31:0] W2  = 32'h0109_5020;
  localparam logic [31:0] W16 = 32'h8C0B_0010;
  localparam logic [31:0] W17 = 32'h8C0C_0014;
  localparam logic [31:0] W255 = 32'h2401_0005;
  localparam logic [31:0] HW  = 32'hFFFF_FFFF;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .start       (start),
    .stallF      (stallF),
    .PCSrcD      (PCSrcD),
    .PCBranchD   (PCBranchD),
    .instrD      (instrD),
    .PCPlus4D    (PCPlus4D),
    .validD      (validD),
    .pcF         (pcF),
    .halted      (halted),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic go);
    imem_we    = 1'b1;
    imem_addr  = a;
    imem_wdata = d;
    start      = go;
    tick();
    imem_we = 1'b0;
    start   = 1'b0;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                          input logic v, input logic [31:0] pc);
    chk({tag, ".instrD"}, instrD, ins);
    chk({tag, ".PCPlus4D"}, PCPlus4D, p4);
    chk({tag, ".validD"}, {31'd0, validD}, {31'd0, v});
    chk({tag, ".pcF"}, pcF, pc);
  endtask

  task automatic chk_reset(input string tag);
    chk_ifid(tag, 32'd0, 32'd0, 1'b0, 32'd0);
    chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
    chk({tag, ".fetch_count"}, fetch_count, 32'd0);
    chk({tag, ".stall_count"}, stall_count, 32'd0);
  endtask

  initial begin
    reset = 1'b1; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    start = 1'b0; stallF = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset("rst0");

    // Program load; the last write shares its cycle with start.
    wr(8'd0, W0, 1'b0);
    wr(8'd1, W1, 1'b0);
    wr(8'd2, W2, 1'b0);
    wr(8'd3, HW, 1'b0);
    wr(8'd16, W16, 1'b0);
    wr(8'd17, W17, 1'b0);
    wr(8'd255, W255, 1'b0);
    chk_ifid("load_idle", 32'd0, 32'd0, 1'b0, 32'd0);
    wr(8'd18, HW, 1'b1);
    chk_ifid("start", 32'd0, 32'd0, 1'b0, 32'd0);

    tick(); chk_ifid("f0", W0, 32'd4, 1'b1, 32'd4);
    tick(); chk_ifid("f1", W1, 32'd8, 1'b1, 32'd8);

    // Two stall cycles; the second also carries a redirect that must be ignored.
    stallF = 1'b1;
    tick(); chk_ifid("stall1", W1, 32'd8, 1'b1, 32'd8);
    PCSrcD = 1'b1; PCBranchD = 32'h0000_0040;
    tick(); chk_ifid("stall2", W1, 32'd8, 1'b1, 32'd8);
    chk("stall_count", stall_count, 32'd2);
    stallF = 1'b0; PCSrcD = 1'b0;
    tick(); chk_ifid("f2", W2, 32'd12, 1'b1, 32'd12);

    tick(); chk_ifid("halt", 32'd0, 32'd0, 1'b0, 32'd12);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("fc_halt", fetch_count, 32'd3);

    // Everything is ignored in HALT, including a write to index 0.
    stallF = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h80; start = 1'b1;
    imem_we = 1'b1; imem_addr = 8'd0; imem_wdata = 32'hDEAD_BEEF;
    tick(); tick();
    chk_ifid("halt_hold", 32'd0, 32'd0, 1'b0, 32'd12);
    chk("halt_sc", stall_count, 32'd2);
    chk("halt_stays", {31'd0, halted}, 32'd1);
    stallF = 1'b0; PCSrcD = 1'b0; start = 1'b0; imem_we = 1'b0;

    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset("rst1");
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_ifid("rerun0", W0, 32'd4, 1'b1, 32'd4);

    // Redirect to 0x42: aligned to 0x40, one bubble, then imem[16].
    PCSrcD = 1'b1; PCBranchD = 32'h0000_0042;
    tick(); chk_ifid("br_bubble", 32'd0, 32'd0, 1'b0, 32'h40);
    PCSrcD = 1'b0;
    tick(); chk_ifid("br_tgt", W16, 32'h44, 1'b1, 32'h44);
    tick(); chk_ifid("br_tgt1", W17, 32'h48, 1'b1, 32'h48);

    // Halt word in fetch discarded by a redirect; 0x400 aliases to index 0.
    PCSrcD = 1'b1; PCBranchD = 32'h0000_0400;
    tick(); chk_ifid("halt_br", 32'd0, 32'd0, 1'b0, 32'h400);
    chk("no_halt", {31'd0, halted}, 32'd0);
    PCSrcD = 1'b0;
    tick(); chk_ifid("alias", W0, 32'h404, 1'b1, 32'h404);

    // PC wrap at the top of the address space.
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFF;
    tick(); chk("wrap_pc", pcF, 32'hFFFF_FFFC);
    PCSrcD = 1'b0;
    tick(); chk_ifid("wrap", W255, 32'd0, 1'b1, 32'd0);

    PCSrcD = 1'b1; PCBranchD = 32'h0000_0020;
    tick(); chk("pc20", pcF, 32'h20);
    chk("fc_run", fetch_count, 32'd5);
    PCSrcD = 1'b0;

    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset("rst2");
    tick(); chk_ifid("load_nofetch", 32'd0, 32'd0, 1'b0, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_ifid("retain0", W0, 32'd4, 1'b1, 32'd4);
    tick(); chk_ifid("retain1", W1, 32'd8, 1'b1, 32'd8);
    chk("fc_retain", fetch_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
